// File: rtl/ctrl_pipe.sv
// Control-word pipeline: STAGES registered stages fed from ID, with per-stage stall and flush.
// Optional feature: define CTRL_PIPE_AUTO_BUBBLE_EN to insert bubbles behind a stalled upstream.
module ctrl_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            din,
    input  logic                        valid_in,
    input  logic                        stall_src,
    input  logic [STAGES-1:0]           stall,
    input  logic [STAGES-1:0]           flush,
    output logic [STAGES*WIDTH-1:0]     dout,
    output logic [STAGES-1:0]           valid_out,
    output logic [$clog2(STAGES+1)-1:0] inflight
);

    localparam int unsigned CntW = $clog2(STAGES + 1);

`ifdef CTRL_PIPE_AUTO_BUBBLE_EN
    localparam bit AutoBubble = 1'b1;
`else
    localparam bit AutoBubble = 1'b0;
`endif

    logic [WIDTH-1:0]  word_q   [STAGES];
    logic [WIDTH-1:0]  word_d   [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;

    logic [WIDTH-1:0]  up_word  [STAGES];
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] up_stall;

    // Upstream view of every stage, taken from pre-edge register values.
    always_comb begin
        up_word[0]  = din;
        up_valid[0] = valid_in;
        up_stall[0] = stall_src;
        for (int k = 1; k < STAGES; k++) begin
            up_word[k]  = word_q[k-1];
            up_valid[k] = valid_q[k-1];
            up_stall[k] = stall[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            word_d[k]  = up_word[k];
            valid_d[k] = up_valid[k];
            if (flush[k]) begin
                word_d[k]  = '0;
                valid_d[k] = 1'b0;
            end else if (stall[k]) begin
                word_d[k]  = word_q[k];
                valid_d[k] = valid_q[k];
            end else if (up_stall[k] && AutoBubble) begin
                word_d[k]  = '0;
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                word_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            dout[k*WIDTH +: WIDTH] = word_q[k];
        end
    end

    assign valid_out = valid_q;

    always_comb begin
        inflight = '0;
        for (int k = 0; k < STAGES; k++) begin
            inflight = inflight + CntW'(valid_q[k]);
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe (WIDTH=8, STAGES=3); honours CTRL_PIPE_AUTO_BUBBLE_EN.
module tb_ctrl_pipe;

    localparam int W = 8;
    localparam int S = 3;

`ifdef CTRL_PIPE_AUTO_BUBBLE_EN
    localparam bit Bubble = 1'b1;
`else
    localparam bit Bubble = 1'b0;
`endif

    typedef struct packed {
        logic [S*W-1:0] word;
        logic [S-1:0]   valid;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   din = '0;
    logic           valid_in = 1'b0;
    logic           stall_src = 1'b0;
    logic [S-1:0]   stall = '0;
    logic [S-1:0]   flush = '0;
    logic [S*W-1:0] dout;
    logic [S-1:0]   valid_out;
    logic [1:0]     inflight;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] mw [S];
    logic [S-1:0] mv;
    exp_t         sb [$];

    ctrl_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .valid_in  (valid_in),
        .stall_src (stall_src),
        .stall     (stall),
        .flush     (flush),
        .dout      (dout),
        .valid_out (valid_out),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < S; k++) mw[k] = '0;
        mv = '0;
    endtask

    // Apply one cycle of stimulus, predict the post-edge state, then compare.
    task automatic drive(input logic [W-1:0] d, input logic v, input logic ss,
                         input logic [S-1:0] st, input logic [S-1:0] fl);
        logic [W-1:0] nw [S];
        logic [S-1:0] nv;
        exp_t         e;
        exp_t         got;
        din = d; valid_in = v; stall_src = ss; stall = st; flush = fl;
        for (int k = 0; k < S; k++) begin
            logic [W-1:0] uw;
            logic         uv;
            logic         us;
            uw = (k == 0) ? d  : mw[(k == 0) ? 0 : k-1];
            uv = (k == 0) ? v  : mv[(k == 0) ? 0 : k-1];
            us = (k == 0) ? ss : st[(k == 0) ? 0 : k-1];
            if (fl[k])             begin nw[k] = '0;    nv[k] = 1'b0;  end
            else if (st[k])        begin nw[k] = mw[k]; nv[k] = mv[k]; end
            else if (us && Bubble) begin nw[k] = '0;    nv[k] = 1'b0;  end
            else                   begin nw[k] = uw;    nv[k] = uv;    end
        end
        for (int k = 0; k < S; k++) begin
            mw[k] = nw[k];
            e.word[k*W +: W] = nw[k];
        end
        mv = nv;
        e.valid = nv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        got.word = dout;
        got.valid = valid_out;
        check_eq("sb_dout", 32'(got.word), 32'(e.word));
        check_eq("sb_valid", 32'(got.valid), 32'(e.valid));
        check_eq("sb_inflight", 32'(inflight), 32'($countones(e.valid)));
    endtask

    task automatic fill();
        drive(8'h11, 1'b1, 1'b0, '0, '0);
        drive(8'h22, 1'b1, 1'b0, '0, '0);
        drive(8'h33, 1'b1, 1'b0, '0, '0);
    endtask

    initial begin
        model_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_dout", 32'(dout), 32'h0);
        check_eq("rst_valid", 32'(valid_out), 32'h0);
        check_eq("rst_inflight", 32'(inflight), 32'h0);
        din = 8'hAA; valid_in = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_ignores_in", 32'({dout, valid_out}), 32'h0);
        #1 rst = 1'b0;

        // Plain flow
        fill();
        check_eq("flow_dout", 32'(dout), 32'h112233);
        check_eq("flow_valid", 32'(valid_out), 32'h7);
        check_eq("flow_inflight", 32'(inflight), 32'd3);

        // Stage 0 stalled for one edge
        drive(8'h00, 1'b0, 1'b0, 3'b001, 3'b000);
        if (Bubble) begin
            check_eq("stall0_dout", 32'(dout), 32'h220033);
            check_eq("stall0_valid", 32'(valid_out), 32'h5);
            check_eq("stall0_inflight", 32'(inflight), 32'd2);
        end else begin
            check_eq("stall0_dout", 32'(dout), 32'h223333);
            check_eq("stall0_valid", 32'(valid_out), 32'h7);
            check_eq("stall0_inflight", 32'(inflight), 32'd3);
        end

        // Flush overrides stall on stage 1
        fill();
        drive(8'h44, 1'b1, 1'b0, 3'b010, 3'b010);
        check_eq("flush_over_stall_word", 32'(dout[W +: W]), 32'h00);
        check_eq("flush_over_stall_valid", 32'(valid_out[1]), 32'h0);
        check_eq("flush_over_stall_s0", 32'(dout[0 +: W]), 32'h44);

        // Asynchronous reset between edges
        fill();
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_dout", 32'(dout), 32'h0);
        check_eq("async_rst_valid", 32'(valid_out), 32'h0);
        check_eq("async_rst_inflight", 32'(inflight), 32'h0);
        #1 rst = 1'b0;
        model_reset();
        drive(8'h44, 1'b1, 1'b0, '0, '0);
        check_eq("post_rst_s0", 32'(dout[0 +: W]), 32'h44);

        // Source stall
        drive(8'h55, 1'b1, 1'b1, '0, '0);
        check_eq("src_stall_s0", 32'(dout[0 +: W]), Bubble ? 32'h00 : 32'h55);
        check_eq("src_stall_v0", 32'(valid_out[0]), Bubble ? 32'h0 : 32'h1);
        drive(8'h55, 1'b1, 1'b0, '0, '0);
        check_eq("src_release_s0", 32'(dout[0 +: W]), 32'h55);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  3'($urandom & $urandom), ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
